// File: rtl/scan_chain_sequencer_pkg.sv
// Shared types and limits for the boundary-scan chain sequencer.
package scan_seq_pkg;

  localparam int SCAN_MAX_LEN = 64;
  localparam int FAIL_CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    RESP
  } scan_state_t;

endpackage

// File: rtl/scan_chain_sequencer_shifter.sv
// Chain-image register: parallel load of the test vector, indexed serial read
// while loading the chain, indexed serial capture while unloading it.
module scan_shifter #(
  parameter int WIDTH = 9,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_bit,
  input  logic             cap_en,
  input  logic [IDX_W-1:0] cap_idx,
  input  logic             cap_bit,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_en) begin
      data_d = load_data;
    end else if (cap_en && (cap_idx < IDX_W'(WIDTH))) begin
      data_d[cap_idx] = cap_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Index one past the last cell reads as 0; the FSM never uses that value.
  assign rd_bit = (rd_idx < IDX_W'(WIDTH)) ? data_q[rd_idx] : 1'b0;
  assign data   = data_q;

endmodule

// File: rtl/scan_chain_sequencer.sv
// Loads a test vector into a boundary-scan chain, pulses capture, unloads the
// chain and returns the captured bits with a masked pass/fail verdict.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// LOAD    | shifting the vector into the chain, one bit per cycle
// CAPTURE | shift low for CAPTURE_CYCLES so the wrapper captures
// UNLOAD  | shifting the response out; extra final cycle forms the verdict
// RESP    | response offered until resp_ready
module scan_chain_sequencer
  import scan_seq_pkg::*;
#(
  parameter int CHAIN_LEN      = 9,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CHAIN_LEN-1:0]  req_vector,
  input  logic [CHAIN_LEN-1:0]  req_expect,
  input  logic [CHAIN_LEN-1:0]  req_mask,
  input  logic                  abort,
  output logic                  scan_shift,
  output logic                  scan_in,
  input  logic                  scan_out,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [CHAIN_LEN-1:0]  resp_data,
  output logic                  resp_fail,
  output logic                  busy,
  output logic [FAIL_CNT_W-1:0] fail_count
);

  localparam int              CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CHAIN_LEN);
  localparam logic [7:0]       CAP_INIT = 8'(CAPTURE_CYCLES - 1);

  if (CHAIN_LEN < 1 || CHAIN_LEN > SCAN_MAX_LEN || CAPTURE_CYCLES < 1 || CAPTURE_CYCLES > 255)
  begin : g_bad_params
    $error("scan_chain_sequencer: parameter out of range");
  end

  scan_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            cap_q, cap_d;
  logic [CHAIN_LEN-1:0]  expect_q, expect_d;
  logic [CHAIN_LEN-1:0]  mask_q, mask_d;
  logic                  shift_q, shift_d;
  logic                  sin_q, sin_d;
  logic                  fail_q, fail_d;
  logic [FAIL_CNT_W-1:0] fcnt_q, fcnt_d;

  logic                  load_en;
  logic                  cap_en;
  logic                  rd_bit;
  logic [CNT_W-1:0]      rd_idx;
  logic [CHAIN_LEN-1:0]  sh_data;

  // Outputs are registered from next-state values so the chain sees clean edges.
  assign rd_idx = cnt_q + CNT_W'(1);

  scan_shifter #(
    .WIDTH (CHAIN_LEN),
    .IDX_W (CNT_W)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_data (req_vector),
    .rd_idx    (rd_idx),
    .rd_bit    (rd_bit),
    .cap_en    (cap_en),
    .cap_idx   (cnt_q),
    .cap_bit   (scan_out),
    .data      (sh_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    expect_d = expect_q;
    mask_d   = mask_q;
    fail_d   = fail_q;
    fcnt_d   = fcnt_q;
    shift_d  = 1'b0;
    sin_d    = 1'b0;
    load_en  = 1'b0;
    cap_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          expect_d = req_expect;
          mask_d   = req_mask;
          cnt_d    = '0;
          load_en  = 1'b1;
          state_d  = LOAD;
          shift_d  = 1'b1;
          sin_d    = req_vector[0];
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
          cap_d   = CAP_INIT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = 1'b1;
          sin_d   = rd_bit;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cap_q == 8'd0) begin
          state_d = UNLOAD;
          cnt_d   = '0;
          shift_d = 1'b1;
        end else begin
          cap_d = cap_q - 8'd1;
        end
      end
      UNLOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_END) begin
          state_d = RESP;
          fail_d  = |((sh_data ^ expect_q) & mask_q);
        end else begin
          cap_en  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = (cnt_q != CNT_LAST);
        end
      end
      RESP: begin
        if (resp_ready) begin
          if (fail_q && (fcnt_q != '1)) begin
            fcnt_d = fcnt_q + FAIL_CNT_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cap_q    <= '0;
      expect_q <= '0;
      mask_q   <= '0;
      shift_q  <= 1'b0;
      sin_q    <= 1'b0;
      fail_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      expect_q <= expect_d;
      mask_q   <= mask_d;
      shift_q  <= shift_d;
      sin_q    <= sin_d;
      fail_q   <= fail_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = sh_data;
  assign resp_fail  = fail_q;
  assign scan_shift = shift_q;
  assign scan_in    = sin_q;
  assign fail_count = fcnt_q;

endmodule

// File: doc/scan_chain_sequencer.md
# scan_chain_sequencer

Sequencer that drives the serial boundary-scan chain (`shift`/`sin`/`sout`) of a wrapped functional block. It accepts a parallel test vector plus an expected response and mask over a valid/ready request port. It then serially loads the chain, releases `shift` for a programmable number of capture cycles, and unloads the chain. It returns the captured bits and a pass/fail verdict over a valid/ready response port. It sits between the test host and the wrapper and shares the wrapper's `clk` and `reset`.

## Interface
- `CHAIN_LEN`, default 9: number of scan cells in the chain (1..64).
- `CAPTURE_CYCLES`, default 1: cycles `shift` is held low between load and unload (1..255).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  high only in IDLE.
- `req_vector`  in  CHAIN_LEN  bits to load; bit i drives the i-th load cycle.
- `req_expect`  in  CHAIN_LEN  expected unload bits.
- `req_mask`  in  CHAIN_LEN  1 = compare this bit.
- `abort`  in  1  synchronous cancel of the operation in flight.
- `scan_shift`  out  1  to wrapper `shift`.
- `scan_in`  out  1  to wrapper `sin`.
- `scan_out`  in  1  from wrapper `sout`.
- `resp_valid`  out  1  response held until accepted.
- `resp_ready`  in  1  response consumed.
- `resp_data`  out  CHAIN_LEN  unloaded bits; bit k is sampled in unload cycle k.
- `resp_fail`  out  1  `|((resp_data ^ expect) & mask)`.
- `busy`  out  1  high in every state except IDLE.
- `fail_count`  out  16  number of failing responses delivered; saturates at 16'hFFFF.

## Operation
- States: IDLE, LOAD, CAPTURE, UNLOAD, RESP.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, latch vector, expect and mask, clear the bit counter, and go to LOAD.
- LOAD:
  - `scan_shift=1`, `scan_in=vector[cnt]`.
  - `cnt` increments each cycle.
  - After CHAIN_LEN cycles, go to CAPTURE.
- CAPTURE:
  - `scan_shift=0`, `scan_in=0`.
  - Runs for CAPTURE_CYCLES cycles, then clears `cnt` and goes to UNLOAD.
- UNLOAD:
  - `scan_shift=1`, `scan_in=0`.
  - `resp_data[cnt] <= scan_out` on each rising edge.
  - After CHAIN_LEN cycles, compute `resp_fail` and go to RESP.
- RESP:
  - `resp_valid=1`; `resp_data` and `resp_fail` are stable.
  - On `resp_ready`: increment `fail_count` if `resp_fail` (saturating), then go to IDLE.
- `abort` in LOAD, CAPTURE or UNLOAD: go to IDLE at the next edge and produce no response. `fail_count` is unchanged. Chain contents are undefined.
- `abort` in IDLE or RESP: ignored.
- Counter width is `$clog2(CHAIN_LEN+1)`. The capture counter is 8 bits.
- Reset values:
  - State IDLE.
  - `scan_shift=0`, `scan_in=0`, `resp_valid=0`, `resp_data=0`, `resp_fail=0`, `busy=0`, `fail_count=0`.

## Timing
- Accept edge is edge 0; the first LOAD cycle follows it.
- `resp_valid` rises 2*CHAIN_LEN + CAPTURE_CYCLES + 1 cycles after the accept edge: 20 cycles for the defaults.
- `scan_shift` and `scan_in` are registered: they change only on clock edges and never glitch within a cycle.
- `req_ready` is combinational from state only, with no dependence on `req_valid`.
- A new request can be accepted no earlier than the cycle after the response handshake: one IDLE cycle minimum between operations.
- `abort` in the same cycle as the last UNLOAD cycle: abort wins and no RESP is entered.
- `reset` mid-operation forces all reset values immediately, without waiting for a clock edge.

## Structure
- Package `scan_seq_pkg` holds:
  - The state enum `scan_state_t` (IDLE, LOAD, CAPTURE, UNLOAD, RESP).
  - The constants `SCAN_MAX_LEN=64` and `FAIL_CNT_W=16`.
- One sub-module, `scan_shifter`:
  - A CHAIN_LEN-bit register with a parallel load, an indexed serial output, and indexed serial capture.
  - It is instantiated once, holding the vector and then the response.
- The FSM and counters live in the top module.

## Test plan
- Loopback (`scan_out` fed from a 9-deep external shift register of `scan_in`), vector 9'h1A5, expect 9'h1A5, mask 9'h1FF:
  - `resp_data` = 9'h1A5, `resp_fail` = 0.
  - `resp_valid` rises at cycle 20 after accept.
- Same loopback with expect 9'h1A4, mask 9'h001:
  - `resp_fail` = 1, `fail_count` = 1 after the handshake.
- Same loopback with expect 9'h1A4, mask 9'h1FE:
  - `resp_fail` = 0 (the mismatching bit is masked).
- `abort` asserted in the 3rd UNLOAD cycle:
  - Next cycle: IDLE, `scan_shift` = 0, `req_ready` = 1.
  - `resp_valid` never rises; `fail_count` is unchanged.
- `resp_ready` held low for 5 cycles in RESP:
  - `resp_valid`, `resp_data` and `resp_fail` are stable throughout.
  - `req_ready` = 0 until the handshake.
- `reset` pulsed mid-LOAD:
  - All outputs return to their reset values immediately.
  - A following request completes normally with the correct latency.
